// File: rtl/cbx_param_ccff.sv
// X-channel connection block: chanx pass-through, ipin muxes for the top and
// bottom grid pins, and a serial configuration chain with a shadow register
// that is copied into the active select store only on a checked commit.
module cbx_param_ccff #(
    parameter int CHAN_WIDTH   = 20,
    parameter int NUM_TOP      = 8,
    parameter int NUM_BOT      = 10,
    parameter int MUX_SIZE     = 8,
    parameter int TRACK_STRIDE = 6
) (
    input  logic                  prog_clk,
    input  logic                  prog_reset_n,
    input  logic [CHAN_WIDTH-1:0] chanx_left_in,
    input  logic [CHAN_WIDTH-1:0] chanx_right_in,
    output logic [CHAN_WIDTH-1:0] chanx_left_out,
    output logic [CHAN_WIDTH-1:0] chanx_right_out,
    output logic [NUM_TOP-1:0]    grid_top_outpad,
    output logic [NUM_BOT-1:0]    grid_bottom_out,
    input  logic                  cfg_head,
    input  logic                  cfg_shift,
    input  logic                  cfg_commit,
    output logic                  cfg_tail,
    output logic                  cfg_valid,
    output logic                  cfg_err
);
    localparam int SEL_W   = $clog2(MUX_SIZE);
    localparam int NUM_MUX = NUM_TOP + NUM_BOT;
    localparam int N_CFG   = NUM_MUX * SEL_W;
    localparam int CNT_W   = $clog2(N_CFG + 2);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(N_CFG);
    localparam logic [CNT_W-1:0] CNT_OVER = CNT_W'(N_CFG + 1);

    // Loader state is a decoding of the shift counter, not a separate register.
    typedef enum logic [1:0] {
        LD_EMPTY,
        LD_LOADING,
        LD_FULL,
        LD_OVER
    } ld_state_t;

    logic [N_CFG-1:0] shadow_q, shadow_d;
    logic [N_CFG-1:0] active_q, active_d;
    logic [CNT_W-1:0] shift_cnt_q, shift_cnt_d;
    logic             cfg_valid_q, cfg_valid_d;
    logic             cfg_err_q, cfg_err_d;
    ld_state_t        ld_state;
    logic [NUM_MUX-1:0] mux_out;

    // Routing tracks pass straight through and are never gated by config.
    assign chanx_left_out  = chanx_right_in;
    assign chanx_right_out = chanx_left_in;

    assign cfg_tail  = shadow_q[N_CFG-1];
    assign cfg_valid = cfg_valid_q;
    assign cfg_err   = cfg_err_q;

    // Classify the shift counter into the loader state.
    always_comb begin
        ld_state = LD_OVER;
        if (shift_cnt_q == '0) begin
            ld_state = LD_EMPTY;
        end else if (shift_cnt_q < CNT_FULL) begin
            ld_state = LD_LOADING;
        end else if (shift_cnt_q == CNT_FULL) begin
            ld_state = LD_FULL;
        end
    end

    // Next-state logic for the chain, counter, active store and flags.
    always_comb begin
        shadow_d    = shadow_q;
        active_d    = active_q;
        shift_cnt_d = shift_cnt_q;
        cfg_valid_d = cfg_valid_q;
        cfg_err_d   = cfg_err_q;
        if (cfg_shift && cfg_commit) begin
            // Ambiguous request: do nothing except flag it.
            cfg_err_d = 1'b1;
        end else if (cfg_shift) begin
            shadow_d = {shadow_q[N_CFG-2:0], cfg_head};
            if (shift_cnt_q != CNT_OVER) begin
                shift_cnt_d = shift_cnt_q + 1'b1;
            end
        end else if (cfg_commit) begin
            shift_cnt_d = '0;
            if (ld_state == LD_FULL) begin
                active_d    = shadow_q;
                cfg_valid_d = 1'b1;
            end else begin
                cfg_err_d = 1'b1;
            end
        end
    end

    // Configuration registers; shadow is kept after commit for readback.
    always_ff @(posedge prog_clk or negedge prog_reset_n) begin
        if (!prog_reset_n) begin
            shadow_q    <= '0;
            active_q    <= '0;
            shift_cnt_q <= '0;
            cfg_valid_q <= 1'b0;
            cfg_err_q   <= 1'b0;
        end else begin
            shadow_q    <= shadow_d;
            active_q    <= active_d;
            shift_cnt_q <= shift_cnt_d;
            cfg_valid_q <= cfg_valid_d;
            cfg_err_q   <= cfg_err_d;
        end
    end

    // One combinational mux per ipin. Input pair p of pin i taps track
    // (i + p*TRACK_STRIDE) mod CHAN_WIDTH; even inputs come from the left,
    // odd inputs from the right.
    genvar gi, gj;
    generate
        for (gi = 0; gi < NUM_MUX; gi++) begin : g_mux
            localparam int PIN = (gi < NUM_TOP) ? gi : gi - NUM_TOP;
            logic [MUX_SIZE-1:0] mux_in;
            logic [SEL_W-1:0]    sel;

            for (gj = 0; gj < MUX_SIZE; gj++) begin : g_in
                localparam int TRK = (PIN + (gj / 2) * TRACK_STRIDE) % CHAN_WIDTH;
                if (gj % 2 == 0) begin : g_left
                    assign mux_in[gj] = chanx_left_in[TRK];
                end else begin : g_right
                    assign mux_in[gj] = chanx_right_in[TRK];
                end
            end

            assign sel = active_q[gi*SEL_W +: SEL_W];
            assign mux_out[gi] = (cfg_valid_q && ({1'b0, sel} < (SEL_W+1)'(MUX_SIZE)))
                               ? mux_in[sel] : 1'b0;
        end
    endgenerate

    assign grid_top_outpad = mux_out[NUM_TOP-1:0];
    assign grid_bottom_out = mux_out[NUM_MUX-1:NUM_TOP];

endmodule
